rc4_prga_decrypt: RTL and testbench
===================================

Name: rc4_prga_decrypt

Overview:
- RC4 pseudo-random generation and decrypt stage. Sits directly downstream of the key-schedule shuffle stage.
- Once the shuffle reports finish, this block walks the shuffled S array in s_mem, swapping entries per PRGA. It XORs each keystream byte with the encrypted ROM byte and writes plaintext to the decrypted RAM.
- It also flags any plaintext byte outside lowercase/space, so the key-search controller can reject the key early.

Parameters:
- MSG_LEN, 32, number of message bytes to decrypt (1..256).
- K_W, 5, width of ROM/RAM byte index; must satisfy 2**K_W >= MSG_LEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  level; begin decryption (asserted after shuffle finish)
- finish  out  1  high while in DONE
- bad_char  out  1  sticky; a non-{a..z, space} byte was produced this run
- s_addr  out  8  S memory address
- s_wdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- s_rdata  in  8  S memory read data
- rom_addr  out  K_W  encrypted ROM address
- rom_rdata  in  8  encrypted ROM data
- ram_addr  out  K_W  decrypted RAM address
- ram_wdata  out  8  decrypted RAM write data
- ram_wren  out  1  decrypted RAM write enable

Behaviour:
- Memory timing: all memories are synchronous read. An address driven in cycle t gives data sampled at the end of cycle t+1, so every read is a RD state followed by a WT state. Address is held through both states.
- Registers: i (8b), j (8b), k (K_W b), si, sj, f (8b). All arithmetic is mod 256 with natural 8-bit wrap.
- Reset: state=IDLE; i=j=k=si=sj=f=0; finish=0; bad_char=0; all wren=0; all addresses/wdata=0. Reset mid-run aborts immediately, with no further writes.
- IDLE: on start=1, load i=1, j=0, k=0, clear bad_char, go to RD_SI. Otherwise stay.
- RD_SI: s_addr=i → WT_SI.
- WT_SI: s_addr=i; si<=s_rdata → CALC_J.
- CALC_J: j<=j+si → RD_SJ.
- RD_SJ: s_addr=j → WT_SJ.
- WT_SJ: s_addr=j; sj<=s_rdata → WR_SJ.
- WR_SJ: s_addr=j, s_wdata=si, s_wren=1 → WR_SI.
- WR_SI: s_addr=i, s_wdata=sj, s_wren=1 → RD_F.
- RD_F: s_addr=si+sj, rom_addr=k → WT_F.
- WT_F: same addresses held; f<=s_rdata; enc byte latched → WR_OUT.
- WR_OUT: ram_addr=k, ram_wdata=f^enc, ram_wren=1.
  - If the byte is not in 8'h61..8'h7A and not 8'h20, set bad_char.
  - If the byte is bad or k==MSG_LEN-1, go to DONE.
  - Else k<=k+1, i<=i+1, go to RD_SI.
- DONE: finish=1; bad_char holds. If start=1, restart exactly as from IDLE (finish drops next cycle). If start=0, remain in DONE.
- Ordering and latency:
  - Exactly 10 cycles per byte.
  - When i==j, both swap writes hit the same address; the second write (sj) is the final value, which equals the original.
  - The first RD_SI occurs the cycle after start is sampled. finish rises 10·N+1 cycles after the start-sampling edge for N bytes processed.
- Write enables are single-cycle, only in WR_SJ, WR_SI and WR_OUT. At most one memory write per cycle.
- i wraps 255→0 naturally. j is never reset within a run.

Test Plan:
- Identity S (S[x]=x), MSG_LEN=2, enc[0]=8'h63, enc[1]=8'h67, start → ram[0]=8'h61, ram[1]=8'h62. Final S[2]=3, S[3]=2, bad_char=0. finish high 21 cycles after start is sampled.
- Identity S, enc[0]=8'h00 → ram[0]=8'h02 written, bad_char=1, finish after 11 cycles, no ram write at address 1.
- i==j case: identity S, first byte (i=1, j=1) → both swap writes to address 1 with data 1; S is unchanged afterwards.
- Reset asserted during WR_SJ of byte 3 → next cycle all wren=0 and finish=0; S, RAM and ROM see no further accesses until the next start.
- Full run with MSG_LEN=32 against a software RC4 model, using a shuffle-stage output for key 24'h000249 → RAM matches the model byte-for-byte. s_wren is only ever paired with addresses i or j.
- Start held high in DONE → new run begins with i=1, j=0, bad_char cleared; finish low for the next 10·N cycles.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decrypt stage. It walks the shuffled S array,
// swaps entries as the PRGA requires, XORs each keystream byte with the
// encrypted ROM byte, writes the plaintext to RAM, and stops early on any byte
// outside {a..z, space}.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int K_W     = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           finish,
  output logic           bad_char,
  output logic [7:0]     s_addr,
  output logic [7:0]     s_wdata,
  output logic           s_wren,
  input  logic [7:0]     s_rdata,
  output logic [K_W-1:0] rom_addr,
  input  logic [7:0]     rom_rdata,
  output logic [K_W-1:0] ram_addr,
  output logic [7:0]     ram_wdata,
  output logic           ram_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, CALC_J, RD_SJ, WT_SJ,
    WR_SJ, WR_SI, RD_F, WT_F, WR_OUT, DONE
  } state_t;

  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

  state_t         state, state_nxt;
  logic [7:0]     i, j, si, sj, f, enc;
  logic [K_W-1:0] k;
  logic [7:0]     out_byte;
  logic           byte_bad, last_byte;

  // Plaintext byte and its classification, valid during WR_OUT.
  always_comb begin
    out_byte  = f ^ enc;
    byte_bad  = !((out_byte >= 8'h61 && out_byte <= 8'h7A) || out_byte == 8'h20);
    last_byte = (k == K_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: ten states per byte, early exit on a bad byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_SI;
      RD_SI:   state_nxt = WT_SI;
      WT_SI:   state_nxt = CALC_J;
      CALC_J:  state_nxt = RD_SJ;
      RD_SJ:   state_nxt = WT_SJ;
      WT_SJ:   state_nxt = WR_SJ;
      WR_SJ:   state_nxt = WR_SI;
      WR_SI:   state_nxt = RD_F;
      RD_F:    state_nxt = WT_F;
      WT_F:    state_nxt = WR_OUT;
      WR_OUT:  state_nxt = (byte_bad || last_byte) ? DONE : RD_SI;
      DONE:    if (start) state_nxt = RD_SI;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: indices, fetched S values, keystream and cipher byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      f        <= '0;
      enc      <= '0;
      bad_char <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          i        <= 8'd1;
          j        <= 8'd0;
          k        <= '0;
          bad_char <= 1'b0;
        end
        WT_SI:  si <= s_rdata;
        CALC_J: j  <= j + si;
        WT_SJ:  sj <= s_rdata;
        WT_F: begin
          f   <= s_rdata;
          enc <= rom_rdata;
        end
        WR_OUT: begin
          if (byte_bad) bad_char <= 1'b1;
          if (!(byte_bad || last_byte)) begin
            k <= k + K_W'(1);
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs decoded from state; addresses hold through RD/WT pairs.
  always_comb begin
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    rom_addr  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    finish    = 1'b0;
    case (state)
      RD_SI, WT_SI: s_addr = i;
      RD_SJ, WT_SJ: s_addr = j;
      WR_SJ: begin
        s_addr  = j;
        s_wdata = si;
        s_wren  = 1'b1;
      end
      WR_SI: begin
        s_addr  = i;
        s_wdata = sj;
        s_wren  = 1'b1;
      end
      RD_F, WT_F: begin
        s_addr   = si + sj;
        rom_addr = k;
      end
      WR_OUT: begin
        ram_addr  = k;
        ram_wdata = out_byte;
        ram_wren  = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: a 2-byte instance for the small directed cases
// and a 32-byte instance for full RC4 runs against a plain software model.
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // Instance A: MSG_LEN=2
  logic       a_reset, a_start, a_finish, a_bad, a_s_wren, a_ram_wren;
  logic [7:0] a_s_addr, a_s_wdata, a_s_rdata, a_rom_rdata, a_ram_wdata;
  logic [0:0] a_rom_addr, a_ram_addr;
  logic [7:0] a_smem [256];
  logic [7:0] a_rom [2];
  logic [7:0] a_ram [2];
  logic [15:0] a_slog [$];
  logic [15:0] a_rlog [$];

  // Instance B: MSG_LEN=32
  logic       b_reset, b_start, b_finish, b_bad, b_s_wren, b_ram_wren;
  logic [7:0] b_s_addr, b_s_wdata, b_s_rdata, b_rom_rdata, b_ram_wdata;
  logic [4:0] b_rom_addr, b_ram_addr;
  logic [7:0] b_smem [256];
  logic [7:0] b_rom [32];
  logic [7:0] b_ram [32];
  logic [15:0] b_slog [$];
  logic [15:0] b_rlog [$];

  rc4_prga_decrypt #(.MSG_LEN(2), .K_W(1)) u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .finish(a_finish), .bad_char(a_bad),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wren(a_s_wren), .s_rdata(a_s_rdata),
    .rom_addr(a_rom_addr), .rom_rdata(a_rom_rdata),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_wren(a_ram_wren));

  rc4_prga_decrypt #(.MSG_LEN(32), .K_W(5)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start), .finish(b_finish), .bad_char(b_bad),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wren(b_s_wren), .s_rdata(b_s_rdata),
    .rom_addr(b_rom_addr), .rom_rdata(b_rom_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_wren(b_ram_wren));

  // Synchronous-read memories with write logging.
  always @(posedge clk) begin
    a_s_rdata   <= a_smem[a_s_addr];
    a_rom_rdata <= a_rom[a_rom_addr];
    if (a_s_wren) begin
      a_smem[a_s_addr] = a_s_wdata;
      a_slog.push_back({a_s_addr, a_s_wdata});
    end
    if (a_ram_wren) begin
      a_ram[a_ram_addr] = a_ram_wdata;
      a_rlog.push_back({7'd0, a_ram_addr, a_ram_wdata});
    end
    b_s_rdata   <= b_smem[b_s_addr];
    b_rom_rdata <= b_rom[b_rom_addr];
    if (b_s_wren) begin
      b_smem[b_s_addr] = b_s_wdata;
      b_slog.push_back({b_s_addr, b_s_wdata});
    end
    if (b_ram_wren) begin
      b_ram[b_ram_addr] = b_ram_wdata;
      b_rlog.push_back({3'd0, b_ram_addr, b_ram_wdata});
    end
  end

  // Reference model state
  int m_s [256];
  int m_enc [256];
  int m_pt [256];
  logic [15:0] e_slog [$];
  logic [15:0] e_rlog [$];
  bit e_bad;
  int e_n;

  // Textbook RC4 PRGA over n bytes; gen=1 derives cipher bytes from m_pt.
  task automatic model(input int n, input bit gen);
    int i, j, si, sj, ks, o;
    i = 0; j = 0; e_bad = 0; e_n = 0;
    e_slog.delete(); e_rlog.delete();
    for (int kk = 0; kk < n; kk++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      si = m_s[i]; sj = m_s[j];
      e_slog.push_back(16'(j * 256 + si));
      e_slog.push_back(16'(i * 256 + sj));
      m_s[i] = sj; m_s[j] = si;
      ks = m_s[(si + sj) % 256];
      if (gen) m_enc[kk] = ks ^ m_pt[kk];
      o = ks ^ m_enc[kk];
      e_rlog.push_back(16'(kk * 256 + o));
      e_n++;
      if (!(o == 32 || (o >= 97 && o <= 122))) begin
        e_bad = 1;
        break;
      end
    end
  endtask

  function automatic int qdiff(input logic [15:0] a [$], input logic [15:0] b [$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int x = 0; x < a.size() && x < b.size(); x++) if (a[x] !== b[x]) d++;
    return d;
  endfunction

  function automatic int pt_byte(input bit allow_bad);
    int r;
    if (allow_bad && $urandom_range(0, 11) == 0) return int'($urandom_range(0, 255));
    r = int'($urandom_range(0, 26));
    return (r == 26) ? 32 : 97 + r;
  endfunction

  task automatic ksa(input logic [23:0] key);
    int j, t;
    logic [7:0] kb [3];
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int x = 0; x < 256; x++) m_s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + m_s[x] + int'(kb[x % 3])) % 256;
      t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
    end
  endtask

  task automatic rand_perm();
    int r, t;
    for (int x = 0; x < 256; x++) m_s[x] = x;
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(0, x));
      t = m_s[x]; m_s[x] = m_s[r]; m_s[r] = t;
    end
  endtask

  task automatic a_go(output int c_fin);
    c_fin = -1;
    a_slog.delete(); a_rlog.delete();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (a_finish) begin c_fin = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic b_go(output int c_fin);
    c_fin = -1;
    b_slog.delete(); b_rlog.delete();
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (b_finish) begin c_fin = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    a_reset = 1; b_reset = 1; a_start = 0; b_start = 0;
    repeat (3) @(negedge clk);
    n_tot++;
    if ({a_finish, a_bad, a_s_wren, a_ram_wren} !== 4'b0 ||
        {a_s_addr, a_s_wdata, a_rom_addr, a_ram_addr, a_ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: fin=%b bad=%b swr=%b rwr=%b sa=%h, want all zero",
               a_finish, a_bad, a_s_wren, a_ram_wren, a_s_addr);
    end
    n_tot++;
    if ({b_finish, b_bad, b_s_wren, b_ram_wren} !== 4'b0 ||
        {b_s_addr, b_s_wdata, b_rom_addr, b_ram_addr, b_ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: fin=%b bad=%b swr=%b rwr=%b sa=%h, want all zero",
               b_finish, b_bad, b_s_wren, b_ram_wren, b_s_addr);
    end
    a_reset = 0; b_reset = 0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int c;
    for (int x = 0; x < 256; x++) begin a_smem[x] = 8'(x); m_s[x] = x; end
    a_rom[0] = 8'h63; a_rom[1] = 8'h67; m_enc[0] = 'h63; m_enc[1] = 'h67;
    model(2, 0);
    a_go(c);
    n_tot++;
    if (c !== 21) begin n_bad++; $display("FAIL id_latency: got %0d want 21", c); end
    n_tot++;
    if (a_ram[0] !== 8'h61 || a_ram[1] !== 8'h62) begin
      n_bad++; $display("FAIL id_ram: got %h %h want 61 62", a_ram[0], a_ram[1]);
    end
    n_tot++;
    if (a_smem[2] !== 8'd3 || a_smem[3] !== 8'd2) begin
      n_bad++; $display("FAIL id_swap: S2=%0d S3=%0d want 3 2", a_smem[2], a_smem[3]);
    end
    n_tot++;
    if (a_bad !== 1'b0) begin n_bad++; $display("FAIL id_badchar: got %b want 0", a_bad); end
    n_tot++;
    if (qdiff(a_slog, e_slog) != 0) begin
      n_bad++; $display("FAIL id_swrites: got %0d writes want %0d", a_slog.size(), e_slog.size());
    end
  endtask

  task automatic test_bad_first_i_eq_j();
    int c, diffs;
    for (int x = 0; x < 256; x++) a_smem[x] = 8'(x);
    a_rom[0] = 8'h00; a_rom[1] = 8'h67;
    a_ram[0] = 8'hEE; a_ram[1] = 8'hEE;
    a_go(c);
    n_tot++;
    if (c !== 11) begin n_bad++; $display("FAIL bad_latency: got %0d want 11", c); end
    n_tot++;
    if (a_ram[0] !== 8'h02 || a_ram[1] !== 8'hEE || a_rlog.size() != 1) begin
      n_bad++; $display("FAIL bad_ram: got %h %h (%0d writes) want 02 ee (1)",
                        a_ram[0], a_ram[1], a_rlog.size());
    end
    n_tot++;
    if (a_bad !== 1'b1) begin n_bad++; $display("FAIL bad_flag: got %b want 1", a_bad); end
    n_tot++;
    if (a_slog.size() != 2 || a_slog[0] !== 16'h0101 || a_slog[1] !== 16'h0101) begin
      n_bad++; $display("FAIL ieqj_writes: got %0d writes first %h want 2 x 0101",
                        a_slog.size(), a_slog[0]);
    end
    diffs = 0;
    for (int x = 0; x < 256; x++) if (a_smem[x] !== 8'(x)) diffs++;
    n_tot++;
    if (diffs != 0) begin n_bad++; $display("FAIL ieqj_s: %0d entries changed want 0", diffs); end
  endtask

  task automatic test_restart_held();
    int viol;
    for (int x = 0; x < 256; x++) m_s[x] = int'(a_smem[x]);
    m_pt[0] = pt_byte(0); m_pt[1] = pt_byte(0);
    model(2, 1);
    a_rom[0] = 8'(m_enc[0]); a_rom[1] = 8'(m_enc[1]);
    a_slog.delete(); a_rlog.delete();
    a_start = 1'b1;
    viol = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (a_finish) viol++;
      if (c == 1) begin
        n_tot++;
        if (a_bad !== 1'b0) begin n_bad++; $display("FAIL held_clear: bad=%b want 0", a_bad); end
      end
    end
    n_tot++;
    if (viol != 0) begin n_bad++; $display("FAIL held_finlow: %0d high cycles want 0", viol); end
    @(negedge clk);
    a_start = 1'b0;
    n_tot++;
    if (a_finish !== 1'b1) begin n_bad++; $display("FAIL held_fin21: got %b want 1", a_finish); end
    @(negedge clk);
    n_tot++;
    if (qdiff(a_slog, e_slog) != 0 || qdiff(a_rlog, e_rlog) != 0 || a_bad !== 1'b0) begin
      n_bad++; $display("FAIL held_run: s=%0d r=%0d bad=%b want s=%0d r=%0d bad=0",
                        a_slog.size(), a_rlog.size(), a_bad, e_slog.size(), e_rlog.size());
    end
  endtask

  task automatic test_full_key();
    int c, diffs;
    ksa(24'h000249);
    for (int x = 0; x < 256; x++) b_smem[x] = 8'(m_s[x]);
    for (int x = 0; x < 32; x++) m_pt[x] = pt_byte(0);
    model(32, 1);
    for (int x = 0; x < 32; x++) b_rom[x] = 8'(m_enc[x]);
    b_go(c);
    n_tot++;
    if (c !== 321) begin n_bad++; $display("FAIL key_latency: got %0d want 321", c); end
    for (int x = 0; x < 32; x++) begin
      n_tot++;
      if (b_ram[x] !== 8'(m_pt[x])) begin
        n_bad++; $display("FAIL key_ram[%0d]: got %h want %h", x, b_ram[x], 8'(m_pt[x]));
      end
    end
    n_tot++;
    if (qdiff(b_slog, e_slog) != 0) begin
      n_bad++; $display("FAIL key_swrites: %0d diffs (got %0d want %0d)",
                        qdiff(b_slog, e_slog), b_slog.size(), e_slog.size());
    end
    diffs = 0;
    for (int x = 0; x < 256; x++) if (b_smem[x] !== 8'(m_s[x])) diffs++;
    n_tot++;
    if (diffs != 0 || b_bad !== 1'b0) begin
      n_bad++; $display("FAIL key_final: %0d S diffs bad=%b want 0 0", diffs, b_bad);
    end
  endtask

  task automatic test_random();
    int c;
    for (int it = 0; it < 5; it++) begin
      rand_perm();
      for (int x = 0; x < 256; x++) b_smem[x] = 8'(m_s[x]);
      for (int x = 0; x < 32; x++) begin m_pt[x] = pt_byte(1); m_enc[x] = 0; end
      model(32, 1);
      for (int x = 0; x < 32; x++)
        b_rom[x] = (x < e_n) ? 8'(m_enc[x]) : 8'($urandom_range(0, 255));
      b_go(c);
      n_tot++;
      if (c !== 10 * e_n + 1) begin
        n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, c, 10 * e_n + 1);
      end
      n_tot++;
      if (b_bad !== e_bad) begin n_bad++; $display("FAIL rnd%0d_bad: got %b want %b", it, b_bad, e_bad); end
      n_tot++;
      if (qdiff(b_rlog, e_rlog) != 0 || qdiff(b_slog, e_slog) != 0) begin
        n_bad++; $display("FAIL rnd%0d_writes: r=%0d s=%0d want r=%0d s=%0d", it,
                          b_rlog.size(), b_slog.size(), e_rlog.size(), e_slog.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int viol;
    bit hit;
    rand_perm();
    for (int x = 0; x < 256; x++) b_smem[x] = 8'(m_s[x]);
    for (int x = 0; x < 32; x++) m_pt[x] = pt_byte(0);
    model(32, 1);
    for (int x = 0; x < 32; x++) b_rom[x] = 8'(m_enc[x]);
    b_slog.delete(); b_rlog.delete();
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      if (b_s_wren && b_slog.size() == 4) begin hit = 1; break; end
      @(negedge clk);
    end
    n_tot++;
    if (!hit) begin n_bad++; $display("FAIL mid_find: WR_SJ of byte 3 not seen, want seen"); end
    b_reset = 1'b1;
    @(negedge clk);
    n_tot++;
    if ({b_s_wren, b_ram_wren, b_finish} !== 3'b000) begin
      n_bad++; $display("FAIL mid_abort: swr=%b rwr=%b fin=%b want 000", b_s_wren, b_ram_wren, b_finish);
    end
    @(negedge clk);
    b_reset = 1'b0;
    viol = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (b_s_wren || b_ram_wren || b_finish || b_s_addr != 0 || b_rom_addr != 0 || b_ram_addr != 0)
        viol++;
    end
    n_tot++;
    if (viol != 0) begin n_bad++; $display("FAIL mid_quiet: %0d active cycles want 0", viol); end
    n_tot++;
    if (b_slog.size() != 5 || b_rlog.size() != 2 || b_slog[4] !== e_slog[4]) begin
      n_bad++; $display("FAIL mid_writes: s=%0d r=%0d last=%h want 5 2 %h",
                        b_slog.size(), b_rlog.size(), b_slog[4], e_slog[4]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1; b_reset = 1; a_start = 0; b_start = 0;
    for (int x = 0; x < 256; x++) begin a_smem[x] = 8'(x); b_smem[x] = 8'(x); end
    @(negedge clk);
    test_reset();
    test_identity();
    test_bad_first_i_eq_j();
    test_restart_held();
    test_full_key();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
